// File: rtl/gpr_file_2r1w.sv
// Two-read, one-write general-purpose register file with a base-address R0 rule
// and an on-demand sweep that reloads every register with its preset value.
module gpr_file_2r1w #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int INIT_IDX = 2,
    parameter int INIT_VAL = 1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic [ADDR_W-1:0] RA_Sel,
    input  logic [ADDR_W-1:0] RB_Sel,
    input  logic              BA_A,
    input  logic              BA_B,
    output logic [DATA_W-1:0] RA_Data,
    output logic [DATA_W-1:0] RB_Data,
    input  logic              W_En,
    input  logic [ADDR_W-1:0] W_Sel,
    input  logic [DATA_W-1:0] W_Data,
    input  logic              Init_Start,
    output logic              Busy,
    output logic              Init_Done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   cnt, cnt_next;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic                wr_ok;

    function automatic logic [DATA_W-1:0] preset(input logic [ADDR_W-1:0] idx);
        return (idx == ADDR_W'(INIT_IDX)) ? DATA_W'(INIT_VAL) : '0;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering in simulation.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: every output of an always_comb block gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        Busy       = 1'b0;
        Init_Done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (Init_Start) begin
                    state_next = SWEEP;
                    cnt_next   = '0;
                end
            end
            SWEEP: begin
                Busy = 1'b1;
                if (cnt == ADDR_W'(NUM_REGS - 1)) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DONE: begin
                Init_Done  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // External writes are accepted in IDLE and DONE, dropped during the sweep.
    assign wr_ok = W_En && (state != SWEEP);

    // NOTE: the storage array is reset because the presets must be visible
    // immediately after Clear, so it is built from resettable flops, not a RAM macro.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= preset(ADDR_W'(i));
            end
        end else if (state == SWEEP) begin
            regs[cnt] <= preset(cnt);
        end else if (wr_ok) begin
            regs[W_Sel] <= W_Data;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] sel,
                                                    input logic              ba);
        // Base-address masking wins over forwarding.
        if (ba && sel == '0) begin
            return '0;
        end else if (BYPASS && wr_ok && W_Sel == sel) begin
            return W_Data;
        end else begin
            return regs[sel];
        end
    endfunction

    always_comb begin
        RA_Data = read_port(RA_Sel, BA_A);
        RB_Data = read_port(RB_Sel, BA_B);
    end

endmodule

// File: tb/tb_gpr_file_2r1w.sv
// Bench for gpr_file_2r1w: array-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_gpr_file_2r1w;

    logic        Clock;
    logic        Clear;
    logic [3:0]  RA_Sel, RB_Sel, W_Sel;
    logic        BA_A, BA_B, W_En, Init_Start;
    logic [31:0] RA_Data, RB_Data, W_Data;
    logic        Busy, Init_Done;

    int checks = 0;
    int errors = 0;

    gpr_file_2r1w dut (
        .Clock(Clock), .Clear(Clear),
        .RA_Sel(RA_Sel), .RB_Sel(RB_Sel), .BA_A(BA_A), .BA_B(BA_B),
        .RA_Data(RA_Data), .RB_Data(RB_Data),
        .W_En(W_En), .W_Sel(W_Sel), .W_Data(W_Data),
        .Init_Start(Init_Start), .Busy(Busy), .Init_Done(Init_Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register contents, sweep position (-1 when not sweeping)
    // and whether the completion pulse is due this cycle.
    logic [31:0] m [16];
    int          sweep_idx;
    bit          done_now;

    function automatic logic [31:0] preset_of(input int i);
        return (i == 2) ? 32'd1 : 32'd0;
    endfunction

    always @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < 16; i++) m[i] = preset_of(i);
            sweep_idx = -1;
            done_now  = 1'b0;
        end else if (sweep_idx >= 0) begin
            m[sweep_idx] = preset_of(sweep_idx);
            if (sweep_idx == 15) begin
                sweep_idx = -1;
                done_now  = 1'b1;
            end else begin
                sweep_idx++;
            end
        end else begin
            if (W_En) m[W_Sel] = W_Data;
            if (Init_Start && !done_now) sweep_idx = 0;
            done_now = 1'b0;
        end
    end

    function automatic logic [31:0] model_read(input logic [3:0] sel, input logic ba);
        if (ba && sel == 4'd0) return 32'd0;
        if (W_En && sweep_idx < 0 && W_Sel == sel) return W_Data;
        return m[sel];
    endfunction

    always @(negedge Clock) begin
        if (Clear) begin
            check("model_ra", RA_Data, model_read(RA_Sel, BA_A));
            check("model_rb", RB_Data, model_read(RB_Sel, BA_B));
            check("model_busy", {31'd0, Busy}, {31'd0, sweep_idx >= 0});
            check("model_done", {31'd0, Init_Done}, {31'd0, done_now});
        end
    end

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        W_En = 1'b0; Init_Start = 1'b0; BA_A = 1'b0; BA_B = 1'b0;
    endtask

    int busy_cnt, done_cnt;

    initial begin
        Clear = 1'b0; RA_Sel = '0; RB_Sel = '0; W_Sel = '0; W_Data = '0;
        idle_inputs();
        #12 Clear = 1'b1;
        cyc();

        // 1: presets after reset
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Init_Done}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            RA_Sel = 4'(i); RB_Sel = 4'(15 - i);
            #1;
            check("rst_ra", RA_Data, (i == 2) ? 32'd1 : 32'd0);
            check("rst_rb", RB_Data, (15 - i == 2) ? 32'd1 : 32'd0);
            cyc();
        end

        // 2: write with same-cycle forwarding, then stored value
        W_En = 1'b1; W_Sel = 4'd5; W_Data = 32'hDEADBEEF; RA_Sel = 4'd5; RB_Sel = 4'd5;
        #1;
        check("byp_ra", RA_Data, 32'hDEADBEEF);
        check("byp_rb", RB_Data, 32'hDEADBEEF);
        cyc();
        W_En = 1'b0; W_Data = 32'h0;
        #1;
        check("hold_ra", RA_Data, 32'hDEADBEEF);
        check("hold_rb", RB_Data, 32'hDEADBEEF);

        // 3: R0 is writable but masked by the base-address flag
        W_En = 1'b1; W_Sel = 4'd0; W_Data = 32'h1234;
        cyc();
        W_En = 1'b0; BA_A = 1'b1; BA_B = 1'b0; RA_Sel = 4'd0; RB_Sel = 4'd0;
        #1;
        check("ba_ra", RA_Data, 32'd0);
        check("ba_rb", RB_Data, 32'h1234);
        cyc();
        idle_inputs();

        // 4: fill, sweep, dropped writes, single done pulse
        for (int i = 0; i < 16; i++) begin
            W_En = 1'b1; W_Sel = 4'(i); W_Data = 32'hFFFFFFFF;
            cyc();
        end
        W_En = 1'b0; Init_Start = 1'b1;
        cyc();
        Init_Start = 1'b0; W_En = 1'b1; W_Sel = 4'd3; W_Data = 32'h55;
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (Busy) busy_cnt++;
            if (Init_Done) done_cnt++;
            if (!Busy) W_En = 1'b0;
            cyc();
        end
        check("sweep_busy_cycles", busy_cnt, 32'd16);
        check("sweep_done_pulses", done_cnt, 32'd1);
        for (int i = 0; i < 16; i++) begin
            RA_Sel = 4'(i);
            #1;
            check("post_sweep", RA_Data, (i == 2) ? 32'd1 : 32'd0);
            cyc();
        end

        // 5: reset in the middle of a sweep
        W_En = 1'b1; W_Sel = 4'd10; W_Data = 32'hA5;
        cyc();
        W_En = 1'b0; Init_Start = 1'b1;
        cyc();
        Init_Start = 1'b0;
        for (int k = 0; k < 7; k++) cyc();
        check("mid_busy_before", {31'd0, Busy}, 32'd1);
        #1 Clear = 1'b0;
        #1;
        check("mid_busy", {31'd0, Busy}, 32'd0);
        check("mid_done", {31'd0, Init_Done}, 32'd0);
        Clear = 1'b1; RA_Sel = 4'd10;
        #1;
        check("mid_r10", RA_Data, 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (Init_Done) done_cnt++;
        end
        check("mid_no_done", done_cnt, 32'd0);

        // 6: write and sweep request on the same edge
        Init_Start = 1'b1; W_En = 1'b1; W_Sel = 4'd15; W_Data = 32'h77; RA_Sel = 4'd15;
        cyc();
        Init_Start = 1'b0; W_En = 1'b0; W_Data = 32'h0;
        for (int k = 0; k < 15; k++) begin
            check("r15_held", RA_Data, 32'h77);
            cyc();
        end
        busy_cnt = 0;
        while (Busy && busy_cnt < 10) begin
            busy_cnt++;
            cyc();
        end
        check("r15_sweep_ended", {31'd0, Busy}, 32'd0);
        check("r15_cleared", RA_Data, 32'd0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
